scan_readout: RTL
=================

# scan_readout

Parallel-to-serial readout for scan-chain register banks. On a start request it captures a WIDTH-bit word (typically the `o_q` of a captured register) into a shadow register. It then shifts the word out one bit per enabled cycle on a serial data line. It is the readout end of the scan path, complementing the parallel-load register banks that the scan generator emits.

## Interface
- `WIDTH`, default 10: number of bits captured and shifted; legal range 1..1024.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `i_clk`  input  1: clock; all state updates on posedge.
- `i_rst_n`  input  1: reset, asynchronous, active-low.
- `i_d`  input  WIDTH: parallel word to read out; sampled only at capture.
- `i_start`  input  1: capture request; honoured only in IDLE.
- `i_shift_en`  input  1: advance one bit; honoured only in SHIFT.
- `o_sdo`  output  1: current serial bit.
- `o_sdo_valid`  output  1: high while `o_sdo` carries a chain bit (SHIFT state).
- `o_busy`  output  1: high in SHIFT and DONE.
- `o_done`  output  1: one-cycle pulse after the final bit is consumed.
- `o_bit_idx`  output  CW = $clog2(WIDTH+1): count of bits already shifted out.

## Operation
- Reset (async, any time including mid-transfer):
  - state = IDLE; shadow = 0; count = 0.
  - All outputs 0.
- States:
  - IDLE: `o_busy`=0, `o_sdo_valid`=0, `o_sdo`=0.
    - If `i_start`=1 at a posedge: shadow <= `i_d`, count <= 0, go to SHIFT.
    - `i_shift_en` is ignored in IDLE, including when it coincides with `i_start`.
  - SHIFT: `o_sdo_valid`=1, `o_busy`=1.
    - `o_sdo` = shadow[WIDTH-1] when MSB_FIRST=1, otherwise shadow[0].
    - On a posedge with `i_shift_en`=1:
      - MSB_FIRST=1: shadow shifts left, filling 0.
      - MSB_FIRST=0: shadow shifts right, filling 0.
      - count increments.
    - If count == WIDTH-1 when the shift occurs, go to DONE; count becomes WIDTH.
    - `i_shift_en`=0 holds all state; no timeout.
  - DONE: `o_done`=1, `o_busy`=1, `o_sdo_valid`=0, `o_sdo`=0. Unconditionally go to IDLE on the next posedge.
- `i_start` in SHIFT or DONE is ignored and not queued.
- `o_bit_idx` = count, registered; returns to 0 on entry to IDLE.
- Changes to `i_d` after capture have no effect on the transfer in progress.
- WIDTH=1: SHIFT lasts until the first enabled shift, then DONE.
- Count arithmetic is unsigned CW-bit; it never exceeds WIDTH, so there is no wrap.

## Timing
- Capture latency: `i_start` sampled at edge N → `o_sdo_valid`=1 and first bit on `o_sdo` from edge N onward (registered outputs, valid in cycle N+1).
- Each bit is held stable until the edge at which `i_shift_en`=1 is sampled. The next bit appears after that same edge.
- Full-rate transfer (`i_shift_en` tied high):
  - WIDTH cycles in SHIFT, then 1 cycle DONE.
  - Next `i_start` accepted at the earliest at the edge ending DONE + 1, i.e. in the first IDLE cycle.
  - Start-to-start period is WIDTH+2 cycles.
- `o_done` rises at the edge that consumes the last bit and falls one edge later.
- All outputs are driven from flops; no combinational path from any input to any output.

## Test plan
- Reset release, no stimulus for 20 cycles → all outputs stay 0 and state stays IDLE.
- WIDTH=10, MSB_FIRST=1, `i_d`=10'h2A5, `i_start` pulse, `i_shift_en`=1:
  - `o_sdo` sequence 1,0,1,0,1,0,0,1,0,1 with `o_sdo_valid`=1 for exactly 10 cycles.
  - `o_bit_idx` counts 0..9.
  - `o_done` pulses once, in the cycle after the 10th bit.
- MSB_FIRST=0, `i_d`=10'h2A5, with `i_shift_en` high only every 3rd cycle:
  - Sequence 1,0,1,0,0,1,0,1,0,1.
  - Each bit held 3 cycles.
  - `i_d` changed to 10'h3FF mid-transfer with no effect.
- `i_start` asserted during SHIFT (bit 4) and during DONE → both ignored. A single transfer completes, then the next `i_start` in IDLE captures a new word.
- `i_rst_n` pulsed low at bit 6 of a transfer:
  - All outputs 0 immediately, without waiting for a clock edge.
  - No `o_done`.
  - A new `i_start` after release sends a full 10-bit word from bit 0.
- WIDTH=1, `i_d`=1: `o_sdo`=1 with `o_sdo_valid` for one cycle, then `o_done` pulse, then IDLE.

Source files
------------

// File: rtl/scan_readout_if.sv
// Bus bundle for scan_readout: capture/shift controls toward the block,
// serial data and status back from it.
interface scan_readout_if #(
  parameter int WIDTH = 10
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] i_d;
  logic             i_start;
  logic             i_shift_en;
  logic             o_sdo;
  logic             o_sdo_valid;
  logic             o_busy;
  logic             o_done;
  logic [CW-1:0]    o_bit_idx;

  modport master (
    output i_d, i_start, i_shift_en,
    input  o_sdo, o_sdo_valid, o_busy, o_done, o_bit_idx
  );

  modport slave (
    input  i_d, i_start, i_shift_en,
    output o_sdo, o_sdo_valid, o_busy, o_done, o_bit_idx
  );
endinterface

// File: rtl/scan_readout.sv
// Parallel-to-serial readout for scan-chain register banks: captures a word
// into a shadow register and shifts it out one bit per enabled cycle.
module scan_readout #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  scan_readout_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sdo_valid_q, sdo_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          shadow_d = bus.i_d;
          count_d  = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.i_shift_en) begin
          shadow_d = MSB_FIRST ? (shadow_q << 1) : (shadow_q >> 1);
          count_d  = count_q + CW'(1);
          if (count_q == LAST_IDX) begin
            count_d = FULL_CNT;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered versions of the next state.
    sdo_valid_d = (state_d == ST_SHIFT);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // NOTE: the shadow is reset because o_sdo reads it directly; after WIDTH
  // shifts it is all zeros, so o_sdo is 0 in DONE and IDLE without gating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      count_q     <= '0;
      sdo_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      count_q     <= count_d;
      sdo_valid_q <= sdo_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_sdo       = MSB_FIRST ? shadow_q[WIDTH-1] : shadow_q[0];
  assign bus.o_sdo_valid = sdo_valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_bit_idx   = count_q;
endmodule
